// File: rtl/led_pwm_sched.sv
// Eight-channel LED PWM controller with an Avalon-MM register slave.
// A prescaler drives an 8-bit period counter (255 ticks per period). Duty
// targets are latched into the active duty only at period ends, either
// directly or one step at a time when fading is enabled.
module led_pwm_sched #(
  parameter int CHANNELS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state;
  logic       enable;
  logic       fade_en;
  logic [7:0] prescale;
  logic [7:0] fade_step;
  logic [7:0] pre_cnt;
  logic [7:0] pwm_cnt;
  logic [7:0] fade_cnt;
  logic [7:0] target [CHANNELS];
  logic [7:0] active [CHANNELS];
  logic       period_end_q;
  logic       fade_busy;
  logic       wr;
  logic       run;
  logic       tick;
  logic       period_end;

  assign wr         = chipselect && !write_n;
  assign run        = (state == ST_RUN) && enable;
  assign tick       = run && (pre_cnt >= prescale);
  assign period_end = tick && (pwm_cnt == 8'd254);

  // Software-visible configuration registers and duty targets
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      fade_en   <= 1'b0;
      prescale  <= 8'd0;
      fade_step <= 8'd0;
      for (int i = 0; i < CHANNELS; i++) target[i] <= 8'd0;
    end else if (wr) begin
      case (address)
        4'd0: begin
          enable  <= writedata[0];
          fade_en <= writedata[1];
        end
        4'd1: prescale  <= writedata;
        4'd3: fade_step <= writedata;
        default: begin
          if (address[3]) target[address[2:0]] <= writedata;
        end
      endcase
    end
  end

  // Run/idle state follows the enable bit with one cycle of lag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (enable)  state <= ST_RUN;
        default: if (!enable) state <= ST_IDLE;
      endcase
    end
  end

  // Prescaler and period counter; both sit at zero whenever not running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= 8'd0;
      pwm_cnt <= 8'd0;
    end else if (!run) begin
      pre_cnt <= 8'd0;
      pwm_cnt <= 8'd0;
    end else if (tick) begin
      pre_cnt <= 8'd0;
      pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  // Fade interval counter, counted in period ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fade_cnt <= 8'd0;
    end else if (!run || !fade_en) begin
      fade_cnt <= 8'd0;
    end else if (period_end) begin
      fade_cnt <= (fade_cnt == fade_step) ? 8'd0 : fade_cnt + 8'd1;
    end
  end

  // Active duty moves to the target only at a period end (snap or single step)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) active[i] <= 8'd0;
    end else if (period_end) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!fade_en) begin
          active[i] <= target[i];
        end else if (fade_cnt == fade_step) begin
          if (active[i] < target[i])      active[i] <= active[i] + 8'd1;
          else if (active[i] > target[i]) active[i] <= active[i] - 8'd1;
        end
      end
    end
  end

  // Registered PWM compare and period pulse, aligned to the first output of a period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out      <= '0;
      period_end_q <= 1'b0;
      period_tick  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (state == ST_RUN) && (pwm_cnt < active[i]);
      end
      period_end_q <= period_end;
      period_tick  <= period_end_q;
    end
  end

  // Any channel still away from its target counts as a fade in progress
  always_comb begin
    fade_busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active[i] != target[i]) fade_busy = 1'b1;
    end
  end

  // Zero-wait-state read mux; duty addresses return the active duty
  always_comb begin
    readdata = 8'd0;
    case (address)
      4'd0: readdata = {6'd0, fade_en, enable};
      4'd1: readdata = prescale;
      4'd2: readdata = {6'd0, fade_busy, (state == ST_RUN)};
      4'd3: readdata = fade_step;
      default: begin
        if (address[3]) readdata = active[address[2:0]];
      end
    endcase
  end

endmodule

// File: doc/led_pwm_sched.md
# led_pwm_sched

Avalon-MM-configured eight-channel LED brightness controller. It generates per-channel PWM from a programmable prescaler and an 8-bit period counter. Duty changes are double-buffered to the period boundary and can optionally ramp (fade) one step at a time. Its `pwm_out` bus drives the board LEDs in place of the static PIO output, and CPU software only writes target brightness and timing registers.

## Interface
- `CHANNELS`, 8: number of PWM channels; the register map and widths below assume 8.
- `clk`  in  1  system clock; all logic is synchronous to its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  4  register word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  8  write data.
- `readdata`  out  8  combinational read mux of `address`; zero-wait-state.
- `pwm_out`  out  8  registered PWM outputs, one per channel.
- `period_tick`  out  1  registered one-cycle pulse at each PWM period end.

## Operation
Register map (unlisted addresses read 0, writes ignored):
- 0 CTRL (R/W): bit0 `enable`, bit1 `fade_en`; bits 7:2 read 0.
- 1 PRESCALE (R/W): a count tick occurs every PRESCALE+1 clocks.
- 2 STATUS (RO): bit0 `running` (state RUN), bit1 `fade_busy` (any active≠target).
- 3 FADE_STEP (R/W): number of periods between fade steps is FADE_STEP+1.
- 8..15 DUTY[n] (W): writes `target[n]`. Reads return `active[n]`.

State machine:
- IDLE: `pre_cnt`, `pwm_cnt` and `fade_cnt` are held at 0, and `pwm_out` is 0. Goes to RUN when `enable` is 1.
- RUN: the counters run as described below. Goes to IDLE on the cycle after `enable` is written 0, from any count value.
- `active[]` and `target[]` are retained across IDLE.

Counters in RUN:
- `pre_cnt` increments each clock. A tick occurs when `pre_cnt >= PRESCALE`, and `pre_cnt` then returns to 0. The `>=` compare prevents runaway when PRESCALE is lowered below the current count.
- On a tick, `pwm_cnt` increments 0..254 and wraps from 254 to 0. A tick at 254 is the period end: 255 ticks per period.
- Per channel: next `pwm_out[n] = (pwm_cnt < active[n])`. Duty 0 gives constant low and duty 255 gives constant high.

At each period end:
- `fade_en = 0`: `active[n] <= target[n]` for all n, and `fade_cnt` is held at 0.
- `fade_en = 1`: if `fade_cnt == FADE_STEP`, each `active[n]` moves ±1 toward `target[n]` (no change if equal) and `fade_cnt` is set to 0. Otherwise `fade_cnt` increments.

Arithmetic: all counters are 8-bit unsigned. A fade step never overshoots the target.

Boundary rules:
- A DUTY write on the same cycle as the period end: the period-end update uses the pre-write `target`. The new value applies at the next period end.
- A CTRL write clearing `fade_en` mid-fade: the next period end snaps `active` to `target`.
- A PRESCALE write takes effect on the following clock.
- Reset mid-operation: everything clears immediately. No partial period completes.

## Timing
- Reset values: all registers 0, `active[]` and `target[]` 0, state IDLE, `pwm_out` 0, `period_tick` 0, `readdata` 0.
- Write latency: a register updates on the clock edge of the write and is readable the next cycle.
- `readdata` is combinational, so it is valid in the same cycle as `address`.
- `pwm_out` is registered: it changes one clock after the `pwm_cnt`/`active` values it reflects.
- `period_tick` is high for exactly one clock, the cycle after the period-end tick, coincident with the first `pwm_out` of the new period.
- Enable to first output: `enable` written at cycle t puts state RUN at t+1, and `pwm_out` reflects `pwm_cnt = 0` at t+2.
- Disable: state IDLE one cycle after the write, and `pwm_out` is 0 at the following cycle.

## Test plan
- Reset, then read addresses 0–15: all return 0, and `pwm_out = 0`, `period_tick = 0`.
- PRESCALE = 0, DUTY[0] = 64, DUTY[1] = 255, enable: after the first `period_tick`, ch0 is high for 64 of every 255 clocks, ch1 is constantly high, and the other channels are low. `period_tick` has a period of 255 clocks.
- PRESCALE = 3, DUTY[2] = 128: ch2 is high for 512 of every 1020 clocks. Lower PRESCALE from 200 to 3 while `pre_cnt > 3`: the next tick occurs the cycle after, with no counter wrap.
- `fade_en = 1`, FADE_STEP = 1, DUTY[3] from 0 to 4: `active[3]` reads 1, 2, 3, 4 at every second period end. STATUS bit1 is 1 until 4 is reached, then 0. A DUTY write landing exactly on the period end is deferred one period.
- Disable mid-period: `pwm_out` is 0 within 2 clocks and STATUS bit0 is 0. Re-enable: the period restarts at `pwm_cnt = 0`. Assert `reset_n` mid-fade: all outputs and registers are 0 immediately.
